// File: rtl/ntt4_input_loader_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ntt4_input_loader_if : coefficient stream in, parallel frame out  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface ntt4_input_loader_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [WIDTH-1:0] mod_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data [3:0];
    logic [WIDTH-1:0] out_mod;
    logic             frame_err;

    modport master (
        output in_valid, in_data, in_last, mod_in, out_ready,
        input  in_ready, out_valid, out_data, out_mod, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, mod_in, out_ready,
        output in_ready, out_valid, out_data, out_mod, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ntt4_input_loader.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ntt4_input_loader : ping-pong loader reducing and bit-reversing   |
// | 4-coefficient frames for the NTT butterfly network.  Rev 1.0      |
// +-------------------------------------------------------------------+
module ntt4_input_loader #(
    parameter int WIDTH = 8
) (
    input  wire                  clk,
    input  wire                  rst,
    ntt4_input_loader_if.slave   bus
);
    logic [WIDTH-1:0] r_slot [2][4];
    logic [WIDTH-1:0] r_mod  [2];
    logic             r_full [2];
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_idx;
    logic             r_frame_err;

    logic             w_in_ready;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [1:0]       w_slot;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_reduced;

    assign w_in_ready = !rst && !r_full[r_wr_sel];
    assign w_wr_fire  = bus.in_valid && w_in_ready;
    assign w_rd_fire  = r_full[r_rd_sel] && bus.out_ready;
    assign w_slot     = {r_idx[0], r_idx[1]};

    // The first beat of a frame reduces against the modulus arriving with it.
    assign w_m        = (r_idx == 2'd0) ? bus.mod_in : r_mod[r_wr_sel];
    assign w_reduced  = (w_m != '0) ? (bus.in_data % w_m) : bus.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 4; s++) begin
                    r_slot[b][s] <= '0;
                end
                r_mod[b]  <= '0;
                r_full[b] <= 1'b0;
            end
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_idx       <= 2'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // Read release and write commit always touch different banks.
            if (w_rd_fire) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
            if (w_wr_fire) begin
                r_slot[r_wr_sel][w_slot] <= w_reduced;
                if (r_idx == 2'd0) begin
                    r_mod[r_wr_sel] <= bus.mod_in;
                end
                if (r_idx == 2'd3) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                    r_idx            <= 2'd0;
                    r_frame_err      <= !bus.in_last;
                end else if (bus.in_last) begin
                    r_idx       <= 2'd0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_full[r_rd_sel];
    assign bus.out_mod   = r_mod[r_rd_sel];
    assign bus.frame_err = r_frame_err;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_out_slot
            assign bus.out_data[g] = r_slot[r_rd_sel][g];
        end
    endgenerate
endmodule
`default_nettype wire
